// File: rtl/cache_ram_line_engine.sv
// Line transfer engine: turns one refill/writeback line request into WORDS
// sequential single-word RAM accesses and returns a one-cycle completion pulse.
module cache_ram_line_engine #(
  parameter int BLOCK_SIZE     = 128,
  parameter int WORD_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int RAM_RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [BLOCK_SIZE-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [BLOCK_SIZE-1:0] resp_rdata_o,
  output logic                  busy_o,
  output logic                  ram_read_o,
  output logic [ADDR_W-1:0]     ram_read_addr_o,
  input  logic [WORD_W-1:0]     ram_data_i,
  output logic [ADDR_W-1:0]     ram_write_addr_o,
  output logic [WORD_W-1:0]     ram_data_o,
  output logic [3:0]            wr_strb_o,
  output logic [2:0]            state_o
);

  localparam int WORDS    = BLOCK_SIZE / WORD_W;
  localparam int LINE_OFS = $clog2(BLOCK_SIZE / 8);
  localparam int BYTE_SH  = $clog2(WORD_W / 8);
  localparam int CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Request handshake: a request transfers on a posedge where
  // req_valid_i && req_ready_o; req_ready_o is high only in IDLE, and
  // resp_valid_o is a single-cycle pulse with no back-pressure.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_DRAIN = 3'd2,
    WR       = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [ADDR_W-1:0]         base_q;
  logic [ADDR_W-1:0]         word_addr;
  logic [BLOCK_SIZE-1:0]     wdata_q;
  logic [BLOCK_SIZE-1:0]     line_q, line_nxt;
  logic [BLOCK_SIZE-1:0]     rdata_q;
  logic [CNT_W-1:0]          iss_cnt, cap_cnt;
  logic [RAM_RD_LATENCY-1:0] rd_pipe, rd_pipe_nxt;
  logic                      accept, rd_phase, cap_fire, last_iss, last_cap;

  assign accept    = (state == IDLE) && req_valid_i;
  assign rd_phase  = (state == RD) || (state == RD_DRAIN);
  assign cap_fire  = rd_phase && rd_pipe[RAM_RD_LATENCY-1];
  assign last_iss  = (iss_cnt == CNT_W'(WORDS - 1));
  assign last_cap  = cap_fire && (cap_cnt == CNT_W'(WORDS - 1));
  assign word_addr = base_q + (ADDR_W'(iss_cnt) << BYTE_SH);

  assign resp_rdata_o = rdata_q;
  assign state_o      = state;

  // Each issued read travels down this pipe; the bit leaving the end marks
  // the cycle in which that word is valid on ram_data_i.
  always_comb begin
    rd_pipe_nxt    = rd_pipe << 1;
    rd_pipe_nxt[0] = (state == RD);
  end

  always_comb begin
    line_nxt = line_q;
    if (cap_fire) line_nxt[cap_cnt*WORD_W +: WORD_W] = ram_data_i;
  end

  always_comb begin
    state_nxt        = state;
    req_ready_o      = 1'b0;
    busy_o           = 1'b1;
    resp_valid_o     = 1'b0;
    ram_read_o       = 1'b0;
    ram_read_addr_o  = '0;
    ram_write_addr_o = '0;
    ram_data_o       = '0;
    wr_strb_o        = 4'h0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) state_nxt = req_write_i ? WR : RD;
      end
      RD: begin
        ram_read_o      = 1'b1;
        ram_read_addr_o = word_addr;
        if (last_iss) state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (last_cap) state_nxt = RESP;
      end
      WR: begin
        wr_strb_o        = 4'hF;
        ram_write_addr_o = word_addr;
        ram_data_o       = wdata_q[iss_cnt*WORD_W +: WORD_W];
        if (last_iss) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      iss_cnt <= '0;
      cap_cnt <= '0;
      rd_pipe <= '0;
    end else begin
      state   <= state_nxt;
      rd_pipe <= rd_pipe_nxt;
      if (accept) begin
        base_q  <= req_addr_i & ~ADDR_W'((1 << LINE_OFS) - 1);
        wdata_q <= req_wdata_i;
        iss_cnt <= '0;
        cap_cnt <= '0;
      end
      if (state == RD || state == WR) iss_cnt <= iss_cnt + 1'b1;
      if (cap_fire) begin
        line_q  <= line_nxt;
        cap_cnt <= cap_cnt + 1'b1;
      end
      // The returned line changes only when a refill completes.
      if (last_cap) rdata_q <= line_nxt;
    end
  end

endmodule

// File: tb/tb_cache_ram_line_engine.sv
// Directed bench for cache_ram_line_engine: table of line requests with
// per-cycle expected RAM traffic, plus reset and back-pressure sequences.
module tb_cache_ram_line_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         busy;
  logic         ram_read;
  logic [31:0]  ram_read_addr;
  logic [31:0]  ram_data_in;
  logic [31:0]  ram_write_addr;
  logic [31:0]  ram_data_out;
  logic [3:0]   wr_strb;
  logic [2:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  base;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  logic [31:0] mem [64];

  cache_ram_line_engine dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_write_i      (req_write),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_rdata_o     (resp_rdata),
    .busy_o           (busy),
    .ram_read_o       (ram_read),
    .ram_read_addr_o  (ram_read_addr),
    .ram_data_i       (ram_data_in),
    .ram_write_addr_o (ram_write_addr),
    .ram_data_o       (ram_data_out),
    .wr_strb_o        (wr_strb),
    .state_o          (state_dbg)
  );

  always #5 clk = ~clk;

  // RAM model, one cycle read latency; non-read cycles return garbage.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[20] <= 32'h00000b13;
      mem[21] <= 32'h00000b93;
      mem[22] <= 32'h00000c13;
      mem[23] <= 32'h00000c93;
      mem[60] <= 32'hdead0000;
      mem[61] <= 32'hdead0001;
      mem[62] <= 32'hdead0002;
      mem[63] <= 32'hdead0003;
      ram_data_in <= 32'hbad0bad0;
    end else begin
      ram_data_in <= ram_read ? mem[ram_read_addr[7:2]] : 32'hbad0bad0;
      if (wr_strb == 4'hF) mem[ram_write_addr[7:2]] <= ram_data_out;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_req(input int vi);
    vec_t v;
    int   rc;
    logic iss;
    v = vecs[vi];
    rc = v.wr ? 5 : 6;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d ready_c0", vi), req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 128'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      iss = (c <= 4);
      chk($sformatf("v%0d c%0d ram_read", vi, c), ram_read, !v.wr && iss);
      chk($sformatf("v%0d c%0d rd_addr", vi, c), ram_read_addr,
          (!v.wr && iss) ? v.base + 32'(4 * (c - 1)) : 32'h0);
      chk($sformatf("v%0d c%0d wr_strb", vi, c), wr_strb, (v.wr && iss) ? 4'hF : 4'h0);
      chk($sformatf("v%0d c%0d wr_addr", vi, c), ram_write_addr,
          (v.wr && iss) ? v.base + 32'(4 * (c - 1)) : 32'h0);
      chk($sformatf("v%0d c%0d wr_data", vi, c), ram_data_out,
          (v.wr && iss) ? v.wdata[(c-1)*32 +: 32] : 32'h0);
      chk($sformatf("v%0d c%0d resp_valid", vi, c), resp_valid, c == rc);
      chk($sformatf("v%0d c%0d busy", vi, c), busy, c <= rc);
      chk($sformatf("v%0d c%0d ready", vi, c), req_ready, c > rc);
      if (c == rc) chk($sformatf("v%0d rdata", vi), resp_rdata, v.exp_rdata);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic prev_resp;

    vecs[0] = '{1'b0, 32'h00000050, 32'h00000050, 128'h0,
                128'h00000c93_00000c13_00000b93_00000b13};
    vecs[1] = '{1'b1, 32'h0000002B, 32'h00000020,
                128'h44444444_33333333_22222222_11111111,
                128'h00000c93_00000c13_00000b93_00000b13};
    vecs[2] = '{1'b0, 32'h00000020, 32'h00000020, 128'h0,
                128'h44444444_33333333_22222222_11111111};
    vecs[3] = '{1'b0, 32'hFFFFFFF0, 32'hFFFFFFF0, 128'h0,
                128'hdead0003_dead0002_dead0001_dead0000};
    vecs[4] = '{1'b1, 32'h00001007, 32'h00001000,
                128'h89abcdef_01234567_fedcba98_76543210,
                128'hdead0003_dead0002_dead0001_dead0000};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 128'h0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst ready", req_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst resp_rdata", resp_rdata, 128'h0);
    chk("rst ram_read", ram_read, 1'b0);
    chk("rst rd_addr", ram_read_addr, 32'h0);
    chk("rst wr_addr", ram_write_addr, 32'h0);
    chk("rst wr_data", ram_data_out, 32'h0);
    chk("rst wr_strb", wr_strb, 4'h0);
    @(posedge clk);
    #1;

    for (int vi = 0; vi < 5; vi++) do_req(vi);

    // Continuous valid with a moving address: only IDLE cycles accept.
    prev_resp = 1'b0;
    for (int i = 0; i < 14; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h00000053 + 32'(i * 32'h100);
      @(negedge clk);
      chk($sformatf("hold c%0d ready", i), req_ready, (i == 0) || (i == 7));
      chk($sformatf("hold c%0d resp", i), resp_valid, (i == 6) || (i == 13));
      chk($sformatf("hold c%0d double_resp", i), prev_resp && resp_valid, 1'b0);
      if (i == 1) chk("hold first rd_addr", ram_read_addr, 32'h00000050);
      if (i == 8) chk("hold second rd_addr", ram_read_addr, 32'h00000750);
      prev_resp = resp_valid;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_addr  = 32'h0;
    @(posedge clk);
    #1;

    // Reset in the middle of a refill abandons it.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h00000050;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst c2 ram_read", ram_read, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst ram_read", ram_read, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst ready", req_ready, 1'b1);
    chk("midrst rdata", resp_rdata, 128'h0);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("midrst c%0d resp", c), resp_valid, 1'b0);
      chk($sformatf("midrst c%0d ram_read", c), ram_read, 1'b0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_ram_line_engine.md
Name: cache_ram_line_engine

Overview:
Memory-side line transfer engine between the cache hierarchy's miss/writeback path and the 32-bit teknofest_ram port. It takes one line-granular request: a refill, or a writeback of a BLOCK_SIZE-bit line. It converts the request into WORDS sequential single-word RAM reads or writes, assembles or serialises the line, and returns a one-cycle completion pulse. Everything runs on the single cache clock; the RAM is driven on the same clock.

Parameters:
BLOCK_SIZE, 128, line width in bits
WORD_W, 32, RAM data width in bits
ADDR_W, 32, byte address width
RAM_RD_LATENCY, 1, cycles from the rd_en/rd_addr issue cycle until the word is valid on ram_data_i
(derived) WORDS = BLOCK_SIZE/WORD_W = 4; LINE_OFS = log2(BLOCK_SIZE/8) = 4

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  line request present
req_ready_o  out  1  engine idle, request accepted when req_valid_i & req_ready_o
req_write_i  in  1  1 = writeback, 0 = refill
req_addr_i  in  ADDR_W  line byte address; low LINE_OFS bits ignored (forced 0)
req_wdata_i  in  BLOCK_SIZE  writeback line, word k = bits [32k+31:32k]
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  BLOCK_SIZE  assembled refill line
busy_o  out  1  request in flight (not IDLE)
ram_read_o  out  1  RAM rd_en
ram_read_addr_o  out  ADDR_W  RAM read byte address
ram_data_i  in  WORD_W  RAM read data
ram_write_addr_o  out  ADDR_W  RAM write byte address
ram_data_o  out  WORD_W  RAM write data
wr_strb_o  out  4  RAM byte write enables

Behaviour:
- Reset (rst_i high at posedge):
  - state IDLE; counters cleared.
  - All outputs 0 except req_ready_o=1; resp_rdata_o=0.
  - An in-flight operation is abandoned: no resp pulse, no further RAM strobes. RAM words already written stay written.
- States: IDLE, RD, RD_DRAIN, WR, RESP.
- IDLE:
  - req_ready_o=1, busy_o=0.
  - On accept, latch base = {req_addr_i[ADDR_W-1:4],4'b0}, latch req_wdata_i and req_write_i.
  - Go to WR if write, else RD.
- RD: WORDS consecutive cycles with ram_read_o=1 and ram_read_addr_o = base + 4*k, for k=0..3. Issue counter increments each cycle.
- Capture:
  - Word k is sampled from ram_data_i at the posedge ending the cycle RAM_RD_LATENCY cycles after issue k.
  - It is stored into line bits [32k+31:32k], tracked by a separate capture counter.
  - RD_DRAIN holds with ram_read_o=0 until the last capture.
- After capture WORDS-1, go to RESP. With RAM_RD_LATENCY=1: accept edge at cycle 0, issues in cycles 1-4, captures at the ends of cycles 2-5, resp_valid_o in cycle 6.
- resp_rdata_o updates only at refill completion and holds until the next refill completes. Writebacks do not change it.
- WR: WORDS consecutive cycles with wr_strb_o=4'hF, ram_write_addr_o = base + 4*k and ram_data_o = word k. Then RESP. resp_valid_o comes in cycle 5 after the accept edge.
- RESP: resp_valid_o=1 for exactly one cycle, busy_o=1, req_ready_o=0. Next state IDLE.
- req_ready_o is high only in IDLE. Back-to-back requests therefore have one idle cycle after RESP, and req_valid_i outside IDLE is ignored (not queued).
- Outside the active phases, ram_read_o=0, wr_strb_o=0, and the address/data outputs are 0.
- Address arithmetic is modulo 2^ADDR_W. Because the base is line-aligned, base+4k never carries out of the line. A line at the top of the space (0xFFFFFFF0) issues 0xFFFFFFF0..0xFFFFFFFC with no wrap.
- ram_data_i is ignored outside capture edges.

Test Plan:
- Reset 5 cycles, then hold -> req_ready_o=1, all other outputs 0.
- Refill at req_addr_i=0x50. RAM model holds 0x50..0x5C = 00000b13, 00000b93, 00000c13, 00000c93:
  - ram_read_addr_o sequence is 0x50, 0x54, 0x58, 0x5C in cycles 1-4.
  - resp_valid_o is a single pulse in cycle 6.
  - resp_rdata_o = 0x00000c93_00000c13_00000b93_00000b13.
- Writeback at req_addr_i=0x2B (must align to 0x20) with req_wdata_i = 0x44444444_33333333_22222222_11111111:
  - wr_strb_o=F in cycles 1-4 at addresses 0x20, 0x24, 0x28, 0x2C with data 11111111..44444444.
  - resp_valid_o in cycle 5.
  - A following refill of 0x20 returns the same line.
- Hold req_valid_i high continuously through a refill with a changing req_addr_i:
  - Only the first request is accepted.
  - The next is accepted in the cycle after RESP.
  - resp_valid_o is never high for 2 consecutive cycles.
- Assert rst_i during RD cycle 2 -> next cycle ram_read_o=0, busy_o=0, req_ready_o=1, and no resp_valid_o pulse ever appears for that request.
- Refill at 0xFFFFFFF0 -> addresses 0xFFFFFFF0..0xFFFFFFFC, no wrap to 0; resp_rdata_o correct.
